// File: rtl/cm_sequencer_if.sv
// Context-memory port: the sequencer is the master, context_memory the slave.
// Read data returns one cycle after rd_cm_en.
interface cm_sequencer_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 60
);
  logic              rd_cm_en;
  logic              wr_cm_en;
  logic [ADDR_W-1:0] cm_addr;
  logic [DATA_W-1:0] wr_cm_data;
  logic [DATA_W-1:0] rd_cm_data;

  modport master (
    output rd_cm_en,
    output wr_cm_en,
    output cm_addr,
    output wr_cm_data,
    input  rd_cm_data
  );

  modport slave (
    input  rd_cm_en,
    input  wr_cm_en,
    input  cm_addr,
    input  wr_cm_data,
    output rd_cm_data
  );
endinterface

// File: rtl/cm_sequencer.sv
// Streams a run of context words from context_memory to the configuration datapath
// through a 2-entry output FIFO, and forwards host context-load writes while idle.
module cm_sequencer #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 60
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   ctx_num,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] ctx_data,
  output logic              ctx_valid,
  input  logic              ctx_ready,
  input  logic              host_wr_en,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic              host_wr_ack,
  cm_sequencer_if.master    cm
);

  localparam int              CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(1 << ADDR_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  rd_left_q, rd_left_d;
  logic [CNT_W-1:0]  dlv_left_q, dlv_left_d;
  logic [1:0]        count_q, count_d;
  logic              inflight_q, inflight_d;
  logic              rd_idx_q, rd_idx_d;
  logic              wr_idx_q, wr_idx_d;
  logic              zero_done_q, zero_done_d;
  logic [DATA_W-1:0] fifo_q [2];

  logic              idle;
  logic              start_ok;
  logic [CNT_W-1:0]  n_clamped;
  logic              pop;
  logic              fifo_pop;
  logic              push;
  logic [1:0]        occ_after;
  logic              issue;
  logic              wr_req;

  assign idle      = (state_q == S_IDLE);
  assign start_ok  = idle && start && !abort;
  assign n_clamped = (ctx_num > MAX_N) ? MAX_N : ctx_num;

  // An empty FIFO lets returning read data bypass straight to the output; it is
  // still captured if the datapath stalls, so ctx_data holds steady.
  assign ctx_valid = (count_q != 2'd0) || inflight_q;
  assign ctx_data  = (count_q != 2'd0) ? fifo_q[rd_idx_q] : cm.rd_cm_data;
  assign pop       = ctx_valid && ctx_ready;
  assign fifo_pop  = pop && (count_q != 2'd0);
  assign push      = inflight_q && !(pop && (count_q == 2'd0));

  // Occupancy after this cycle's pop; a new read is allowed only if its word will fit.
  assign occ_after = count_q + 2'(inflight_q) - 2'(pop);
  assign issue     = (state_q == S_RUN) && !abort && (rd_left_q != '0) &&
                     (occ_after < 2'd2);
  assign wr_req    = idle && host_wr_en && !start;

  assign busy        = !idle;
  assign done        = ((state_q == S_DRAIN) && !abort && pop &&
                        (dlv_left_q == CNT_W'(1))) || zero_done_q;
  assign host_wr_ack = wr_req;

  assign cm.rd_cm_en   = issue;
  assign cm.wr_cm_en   = wr_req;
  assign cm.cm_addr    = issue ? ptr_q : (wr_req ? host_addr : '0);
  assign cm.wr_cm_data = wr_req ? host_wr_data : '0;

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block infers a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    rd_left_d   = rd_left_q;
    dlv_left_d  = dlv_left_q;
    count_d     = count_q + 2'(push) - 2'(fifo_pop);
    inflight_d  = issue;
    rd_idx_d    = rd_idx_q ^ fifo_pop;
    wr_idx_d    = wr_idx_q ^ push;
    zero_done_d = start_ok && (n_clamped == '0);

    if (issue) begin
      ptr_d     = ptr_q + 1'b1;
      rd_left_d = rd_left_q - 1'b1;
    end
    if (pop) begin
      dlv_left_d = dlv_left_q - 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_ok && (n_clamped != '0)) begin
          state_d    = S_RUN;
          ptr_d      = start_addr;
          rd_left_d  = n_clamped;
          dlv_left_d = n_clamped;
        end
      end
      S_RUN: begin
        if (issue && (rd_left_q == CNT_W'(1))) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && (dlv_left_q == CNT_W'(1))) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort drops buffered words and forgets the read still in flight.
    if (abort && !idle) begin
      state_d    = S_IDLE;
      count_d    = 2'd0;
      inflight_d = 1'b0;
      rd_idx_d   = 1'b0;
      wr_idx_d   = 1'b0;
      rd_left_d  = '0;
      dlv_left_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      rd_left_q   <= '0;
      dlv_left_q  <= '0;
      count_q     <= 2'd0;
      inflight_q  <= 1'b0;
      rd_idx_q    <= 1'b0;
      wr_idx_q    <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rd_left_q   <= rd_left_d;
      dlv_left_q  <= dlv_left_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      rd_idx_q    <= rd_idx_d;
      wr_idx_q    <= wr_idx_d;
      zero_done_q <= zero_done_d;
    end
  end

  // NOTE: FIFO storage is not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_idx_q] <= cm.rd_cm_data;
  end

endmodule

// File: tb/tb_cm_sequencer.sv
// Bench for cm_sequencer: a context_memory model on the bus, and a reference model that
// predicts the word/address stream of each sequence straight from start_addr and ctx_num.
module tb_cm_sequencer;

  localparam int AW    = 6;
  localparam int DW    = 60;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   ctx_num;
  logic          abort;
  logic          busy;
  logic          done;
  logic [DW-1:0] ctx_data;
  logic          ctx_valid;
  logic          ctx_ready = 1'b0;
  logic          host_wr_en;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wr_data;
  logic          host_wr_ack;

  cm_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) cm_bus ();

  cm_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .start_addr   (start_addr),
    .ctx_num      (ctx_num),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .ctx_data     (ctx_data),
    .ctx_valid    (ctx_valid),
    .ctx_ready    (ctx_ready),
    .host_wr_en   (host_wr_en),
    .host_addr    (host_addr),
    .host_wr_data (host_wr_data),
    .host_wr_ack  (host_wr_ack),
    .cm           (cm_bus)
  );

  always #5 clk = ~clk;

  // context_memory: synchronous read, one-cycle latency
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (cm_bus.wr_cm_en) mem[cm_bus.cm_addr] <= cm_bus.wr_cm_data;
    if (cm_bus.rd_cm_en) cm_bus.rd_cm_data <= mem[cm_bus.cm_addr];
  end

  // reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] addr_q [$];

  int n_cmp = 0, n_err = 0;
  int cyc = 0, words_seq = 0, done_cnt = 0, ack_cnt = 0;
  int ack_cycle = 0, done_cycle = 0, reads_tot = 0, words_tot = 0;
  int overlap_err = 0, buf_err = 0, ack_busy_err = 0;
  int rmode = 0;
  bit last_done_hs = 1'b0, last_done_empty = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // downstream ready: 0 = always, 1 = toggle, 2 = random, other = held low
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       ctx_ready = 1'b1;
      1:       ctx_ready = !ctx_ready;
      2:       ctx_ready = 1'($urandom_range(0, 1));
      default: ctx_ready = 1'b0;
    endcase
  end

  // monitor, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (ctx_valid) begin
        if (exp_q.size() == 0) check("extra_word", 1, 0);
        else begin
          check("ctx_data", ctx_data, exp_q[0]);
          if (ctx_ready) begin
            void'(exp_q.pop_front());
            words_seq++;
            words_tot++;
          end
        end
      end
      if (cm_bus.rd_cm_en) begin
        if (addr_q.size() == 0) check("extra_read", 1, 0);
        else check("rd_addr", cm_bus.cm_addr, addr_q.pop_front());
        reads_tot++;
      end
      if (cm_bus.rd_cm_en && cm_bus.wr_cm_en) overlap_err++;
      if (reads_tot - words_tot > 2) buf_err++;
      if (done) begin
        done_cnt++;
        done_cycle      = cyc;
        last_done_hs    = ctx_valid && ctx_ready;
        last_done_empty = (exp_q.size() == 0);
      end
      if (host_wr_ack) begin
        ack_cnt++;
        ack_cycle = cyc;
        if (busy) ack_busy_err++;
      end
    end
  end

  // Tasks start and end just after a rising edge.
  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_wr_en   = 1'b1;
    host_addr    = a;
    host_wr_data = d;
    ref_mem[a]   = d;
    @(negedge clk); #1;
    check("host_ack", host_wr_ack, 1);
    check("wr_addr", cm_bus.cm_addr, a);
    check("wr_data", cm_bus.wr_cm_data, d);
    @(posedge clk); #1;
    host_wr_en = 1'b0;
  endtask

  task automatic run_seq(input logic [AW-1:0] a, input int n, input int mode, input bit host_hold);
    int m;
    int t;
    m = (n > DEPTH) ? DEPTH : n;
    for (int i = 0; i < m; i++) begin
      exp_q.push_back(ref_mem[(int'(a) + i) % DEPTH]);
      addr_q.push_back(AW'((int'(a) + i) % DEPTH));
    end
    words_seq = 0; done_cnt = 0; ack_cnt = 0; reads_tot = 0; words_tot = 0;
    rmode      = mode;
    start      = 1'b1;
    start_addr = a;
    ctx_num    = (AW+1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    if (m == 0) begin
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      check("zero_rd", cm_bus.rd_cm_en, 0);
    end else begin
      check("busy_after_start", busy, 1);
      check("first_rd_lat", cm_bus.rd_cm_en, 1);
      @(negedge clk); #1;
      check("first_valid_lat", ctx_valid, 1);
    end
    t = 0;
    while (done_cnt == 0 && t < 400) begin
      @(negedge clk); #1;
      t++;
    end
    check("done_seen", done_cnt, 1);
    check("word_count", words_seq, m);
    check("exp_drained", exp_q.size(), 0);
    check("addr_drained", addr_q.size(), 0);
    if (m > 0) check("done_on_last", {last_done_hs, last_done_empty}, 2'b11);
    if (host_hold) begin
      @(negedge clk); #1;
      check("ack_after_done", host_wr_ack, 1);
      check("ack_cycle", ack_cycle, done_cycle + 1);
      @(posedge clk); #1;
      host_wr_en = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("single_done", done_cnt, 1);
    check("idle_after", busy, 0);
    check("ack_count", ack_cnt, host_hold ? 1 : 0);
    exp_q.delete();
    addr_q.delete();
  endtask

  task automatic stop_after3(input bit use_reset);
    int t;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(ref_mem[i]);
      addr_q.push_back(AW'(i));
    end
    words_seq = 0; done_cnt = 0; reads_tot = 0; words_tot = 0;
    rmode      = 0;
    start      = 1'b1;
    start_addr = '0;
    ctx_num    = (AW+1)'(10);
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    do begin
      @(negedge clk); #1;
      t++;
    end while (words_seq < 3 && t < 100);
    check("three_words", words_seq, 3);
    rmode = 3;
    @(posedge clk); #1;
    if (use_reset) begin
      rst_n = 1'b0;
      #1;
      check("rst_valid", ctx_valid, 0);
      check("rst_busy", busy, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
    end else begin
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk); #1;
      check("abort_valid", ctx_valid, 0);
      check("abort_busy", busy, 0);
    end
    exp_q.delete();
    addr_q.delete();
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("stop_no_done", done_cnt, 0);
    check("stop_words", words_seq, 3);
    run_seq(0, 1, 0, 0);
  endtask

  initial begin
    logic [63:0] r;
    rst_n = 1'b0; start = 1'b0; start_addr = '0; ctx_num = '0; abort = 1'b0;
    host_wr_en = 1'b0; host_addr = '0; host_wr_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset_ctl", {busy, done, ctx_valid, host_wr_ack, cm_bus.rd_cm_en, cm_bus.wr_cm_en}, 0);
    check("reset_addr", cm_bus.cm_addr, 0);
    check("reset_wdata", cm_bus.wr_cm_data, 0);
    check("reset_data", ctx_data === '0 || !ctx_valid, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int a = 0; a < DEPTH; a++) begin
      r = {$urandom(), $urandom()};
      host_write(AW'(a), r[DW-1:0]);
    end

    host_write(6'd22, 60'd100000);
    host_write(6'd23, 60'd200000);
    run_seq(6'd22, 2, 0, 0);
    run_seq(6'd62, 4, 0, 0);
    run_seq(6'd0, 8, 1, 0);

    r = {$urandom(), $urandom()};
    host_wr_en   = 1'b1;
    host_addr    = 6'd40;
    host_wr_data = r[DW-1:0];
    ref_mem[40]  = r[DW-1:0];
    run_seq(6'd10, 6, 0, 1);
    run_seq(6'd40, 1, 0, 0);

    run_seq(6'd5, 0, 0, 0);
    run_seq(6'd0, 100, 0, 0);

    stop_after3(1'b0);
    stop_after3(1'b1);

    for (int k = 0; k < 14; k++) begin
      r = {$urandom(), $urandom()};
      host_write(AW'($urandom_range(0, DEPTH - 1)), r[DW-1:0]);
      run_seq(AW'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 127)),
              int'($urandom_range(0, 2)), 0);
    end

    check("rd_wr_overlap", overlap_err, 0);
    check("buffer_bound", buf_err, 0);
    check("ack_while_busy", ack_busy_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
